// File: rtl/brlite_delivery_monitor.sv
// BrLite local-port receive monitor: 4-phase req/ack sink, timestamped log FIFO.
// Optional per-source duplicate filter enabled by defining BRLITE_MON_DEDUP_EN.
module brlite_delivery_monitor #(
  parameter int PE_CNT    = 64,
  parameter int SRC_W     = $clog2(PE_CNT),
  parameter int PAYLOAD_W = 16,
  parameter int TS_W      = 32,
  parameter int LOG_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         ack_o,
  input  logic [SRC_W-1:0]             src_i,
  input  logic [PAYLOAD_W-1:0]         payload_i,
  output logic                         log_valid_o,
  input  logic                         log_ready_i,
  output logic [TS_W-1:0]              log_ts_o,
  output logic [SRC_W-1:0]             log_src_o,
  output logic [PAYLOAD_W-1:0]         log_payload_o,
  output logic [$clog2(LOG_DEPTH):0]   log_count_o,
  output logic                         overflow_o,
  output logic                         dup_o
);

  localparam int AW = $clog2(LOG_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_W + SRC_W + PAYLOAD_W;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_dup;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [TS_W-1:0]  r_ts;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [EW-1:0]    r_mem [LOG_DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (req_i)  w_state_nxt = S_ACK;
      S_ACK:  if (!req_i) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o     = (r_state == S_ACK);
    w_capture = (r_state == S_IDLE) && req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + TS_W'(1);
  end

  // The network never stalls: a full log drops the flit but still acks it.
  assign w_full = (r_count == CW'(LOG_DEPTH));
  assign w_pop  = (r_count != '0) && log_ready_i;
  assign w_push = w_capture && !w_dup && (!w_full || w_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_capture && !w_dup && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= {r_ts, src_i, payload_i};
  end

  assign log_valid_o = (r_count != '0);
  assign log_count_o = r_count;
  assign overflow_o  = r_ovf;
  assign {log_ts_o, log_src_o, log_payload_o} = r_mem[r_rptr];

`ifdef BRLITE_MON_DEDUP_EN
  logic [PE_CNT-1:0]    r_tab_v;
  logic [PAYLOAD_W-1:0] r_tab_p [PE_CNT];
  logic                 r_dup;

  assign w_dup = w_capture && r_tab_v[src_i] && (r_tab_p[src_i] == payload_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tab_v <= '0;
      r_dup   <= 1'b0;
    end else begin
      if (w_push) r_tab_v[src_i] <= 1'b1;
      if (w_dup)  r_dup <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_tab_p[src_i] <= payload_i;
  end

  assign dup_o = r_dup;
`else
  assign w_dup = 1'b0;
  assign dup_o = 1'b0;
`endif

endmodule

// File: tb/tb_brlite_delivery_monitor.sv
// Directed bench for brlite_delivery_monitor with a scoreboard queue of log entries.
// Expectations follow BRLITE_MON_DEDUP_EN when it is defined.
module tb_brlite_delivery_monitor;

  localparam int PE_CNT = 64;
  localparam int SRC_W  = 6;
  localparam int PW     = 16;
  localparam int TS_W   = 32;
  localparam int DEPTH  = 8;

  typedef struct {
    logic [TS_W-1:0]  ts;
    logic [SRC_W-1:0] src;
    logic [PW-1:0]    pl;
  } ent_t;

  logic             clk;
  logic             rst_ni;
  logic             req;
  logic             ack;
  logic [SRC_W-1:0] src;
  logic [PW-1:0]    payload;
  logic             log_valid;
  logic             log_ready;
  logic [TS_W-1:0]  log_ts;
  logic [SRC_W-1:0] log_src;
  logic [PW-1:0]    log_payload;
  logic [3:0]       log_count;
  logic             overflow;
  logic             dup;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] tb_cyc = '0;
  ent_t        sb[$];
  logic        m_ovf;
  logic        m_dup;
  logic        tab_v [PE_CNT];
  logic [PW-1:0] tab_p [PE_CNT];

  brlite_delivery_monitor #(
    .PE_CNT(PE_CNT), .PAYLOAD_W(PW), .TS_W(TS_W), .LOG_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .ack_o(ack),
    .src_i(src), .payload_i(payload),
    .log_valid_o(log_valid), .log_ready_i(log_ready),
    .log_ts_o(log_ts), .log_src_o(log_src), .log_payload_o(log_payload),
    .log_count_o(log_count), .overflow_o(overflow), .dup_o(dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: 0 in the first cycle after reset release.
  always @(posedge clk) begin
    if (!rst_ni) tb_cyc <= '0;
    else         tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_ovf = 1'b0;
    m_dup = 1'b0;
    for (int i = 0; i < PE_CNT; i++) begin
      tab_v[i] = 1'b0;
      tab_p[i] = '0;
    end
  endtask

  function automatic logic is_dup(input logic [SRC_W-1:0] s,
                                  input logic [PW-1:0] p);
`ifdef BRLITE_MON_DEDUP_EN
    return tab_v[s] && (tab_p[s] == p);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; req = 1'b0; log_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    model_clear();
    chk("rst_ack", ack, 0);
    chk("rst_valid", log_valid, 0);
    chk("rst_count", log_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dup", dup, 0);
    chk("rst_cyc", tb_cyc, 0);
  endtask

  // Full 4-phase handshake; caller is at a negedge with ack low.
  task automatic send(input logic [SRC_W-1:0] s, input logic [PW-1:0] p);
    req = 1'b1; src = s; payload = p;
    if (is_dup(s, p)) m_dup = 1'b1;
    else if (sb.size() == DEPTH) m_ovf = 1'b1;
    else begin
      sb.push_back('{tb_cyc, s, p});
      tab_v[s] = 1'b1;
      tab_p[s] = p;
    end
    @(posedge clk); @(negedge clk);
    chk("ack_high", ack, 1);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ack_low", ack, 0);
  endtask

  task automatic drain();
    ent_t e;
    int   guard;
    guard = 0;
    while (sb.size() > 0 && guard < 2 * DEPTH) begin
      e = sb[0];
      chk("drain_count", log_count, sb.size());
      chk("drain_valid", log_valid, 1);
      chk("drain_ts", log_ts, e.ts);
      chk("drain_src", log_src, e.src);
      chk("drain_pl", log_payload, e.pl);
      log_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      log_ready = 1'b0;
      void'(sb.pop_front());
      guard++;
    end
    chk("drain_empty", log_valid, 0);
    chk("drain_count0", log_count, 0);
  endtask

  initial begin
    rst_ni = 1'b0; req = 1'b0; src = '0; payload = '0; log_ready = 1'b0;
    model_clear();
    do_reset();

    // T1: req at cycle 4
    repeat (4) @(negedge clk);
    chk("t1_cyc", tb_cyc, 4);
    req = 1'b1; src = 6'd4; payload = 16'h0001;
    sb.push_back('{32'd4, 6'd4, 16'h0001});
    tab_v[4] = 1'b1; tab_p[4] = 16'h0001;
    @(posedge clk); @(negedge clk);
    chk("t1_ack", ack, 1);
    chk("t1_valid", log_valid, 1);
    chk("t1_ts", log_ts, 4);
    chk("t1_src", log_src, 4);
    chk("t1_pl", log_payload, 16'h0001);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t1_ack_low", ack, 0);
    drain();

    // T2: three back-to-back flits from cycle 80
    while (tb_cyc < 80) @(negedge clk);
    send(6'd0, 16'h0002);
    send(6'd3, 16'h0003);
    send(6'd5, 16'h0004);
    chk("t2_count", log_count, 3);
    chk("t2_order", (sb[0].ts < sb[1].ts) && (sb[1].ts < sb[2].ts), 1);
    drain();

    // T3: overflow on the ninth flit
    for (int i = 0; i < 9; i++) send(SRC_W'(i), PW'(16'h0100 + i));
    chk("t3_count", log_count, 8);
    chk("t3_ovf", overflow, m_ovf);
    chk("t3_ovf1", overflow, 1);
    drain();
    chk("t3_ovf_sticky", overflow, 1);

    // T6: reset while ack is high
    req = 1'b1; src = 6'd10; payload = 16'h0600;
    @(posedge clk); @(negedge clk);
    chk("t6_ack_pre", ack, 1);
    rst_ni = 1'b0; req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t6_ack_drop", ack, 0);
    rst_ni = 1'b1;
    model_clear();
    chk("t6_count", log_count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_dup", dup, 0);
    chk("t6_cyc", tb_cyc, 0);
    send(6'd10, 16'h0600);
    chk("t6_ts0", log_ts, 0);
    drain();

    // T4: full log with a pop in the capture cycle
    for (int i = 0; i < 8; i++) send(SRC_W'(i), PW'(16'h0200 + i));
    chk("t4_full", log_count, 8);
    chk("t4_head_ts", log_ts, sb[0].ts);
    chk("t4_head_pl", log_payload, sb[0].pl);
    req = 1'b1; src = 6'd9; payload = 16'h0300; log_ready = 1'b1;
    void'(sb.pop_front());
    sb.push_back('{tb_cyc, 6'd9, 16'h0300});
    tab_v[9] = 1'b1; tab_p[9] = 16'h0300;
    @(posedge clk); @(negedge clk);
    log_ready = 1'b0;
    chk("t4_ack", ack, 1);
    chk("t4_count", log_count, 8);
    chk("t4_ovf", overflow, 0);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t4_ack_low", ack, 0);
    chk("t4_last_src", sb[DEPTH-1].src, 9);
    drain();

    // T5: repeated flit from one source
    send(6'd3, 16'h0077);
    send(6'd3, 16'h0077);
`ifdef BRLITE_MON_DEDUP_EN
    chk("t5_count", log_count, 1);
    chk("t5_dup", dup, 1);
`else
    chk("t5_count", log_count, 2);
    chk("t5_dup", dup, 0);
`endif
    chk("t5_dup_model", dup, m_dup);
    chk("t5_ovf", overflow, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
